firebird7_in_gate1_tessent_data_mux_seq: RTL

Parametrised, registered successor to the single-channel IJTAG data mux. Selects `data_out` from the functional path or one of NUM_CH IJTAG data channels, with a per-bit override mask. Every source change passes through a programmable safe-value phase, so downstream logic never sees a mixed-source word. Sits between the IJTAG instrument SIBs/TDRs and functional configuration inputs. It also provides a capture register for functional-data readback.

---
 rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv | 15 +
 rtl/firebird7_in_gate1_tessent_data_mux_chsel.sv | 25 ++
 rtl/firebird7_in_gate1_tessent_data_mux_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// Shared types and helpers for the registered IJTAG/functional data mux.
package firebird7_in_gate1_tessent_data_mux_pkg;

  typedef enum logic [1:0] {
    SRC_FUNC  = 2'b00,
    SRC_SAFE  = 2'b01,
    SRC_IJTAG = 2'b10
  } src_e;

  // Out-of-range channel requests fall back to channel 0.
  function automatic int unsigned ch_remap(input int unsigned sel, input int unsigned num_ch);
    return (sel >= num_ch) ? 0 : sel;
  endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_chsel.sv
// Combinational channel select plus per-bit IJTAG/functional merge.
module firebird7_in_gate1_tessent_data_mux_chsel #(
  parameter int unsigned WIDTH  = 19,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH*WIDTH-1:0] i_data,
  input  logic [CH_W-1:0]         i_ch,
  input  logic [WIDTH-1:0]        i_func,
  input  logic [WIDTH-1:0]        i_mask,
  output logic [WIDTH-1:0]        o_data
);

  logic [WIDTH-1:0] w_ch_data;

  always_comb begin
    w_ch_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_ch == CH_W'(k)) w_ch_data = i_data[k*WIDTH +: WIDTH];
    end
  end

  assign o_data = (w_ch_data & i_mask) | (i_func & ~i_mask);

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_seq.sv
// Registered functional/IJTAG data mux with a safe-value phase on every source change.
module firebird7_in_gate1_tessent_data_mux_seq
  import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
  parameter int unsigned      WIDTH       = 19,
  parameter int unsigned      NUM_CH      = 2,
  parameter int unsigned      SAFE_CYCLES = 2,
  parameter logic [WIDTH-1:0] SAFE_VALUE  = '0,
  parameter int unsigned      CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    ijtag_tck,
  input  logic                    ijtag_reset,
  input  logic                    ijtag_select,
  input  logic [CH_W-1:0]         ijtag_ch_sel,
  input  logic [WIDTH-1:0]        functional_data_in,
  input  logic [NUM_CH*WIDTH-1:0] ijtag_data_in,
  input  logic [WIDTH-1:0]        ijtag_bit_mask,
  input  logic                    capture_en,
  output logic [WIDTH-1:0]        data_out,
  output logic [WIDTH-1:0]        captured_data,
  output logic                    switch_busy,
  output logic [1:0]              active_src,
  output logic [CH_W-1:0]         active_ch
);

  localparam int unsigned CNT_W = (SAFE_CYCLES > 1) ? $clog2(SAFE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CntLoad = (SAFE_CYCLES > 0) ? CNT_W'(SAFE_CYCLES - 1) : '0;

  src_e             r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_pend_ijtag, w_pend_ijtag_d;
  logic [CH_W-1:0]  r_pend_ch, w_pend_ch_d;
  logic [CH_W-1:0]  r_active_ch, w_active_ch_d;
  logic [WIDTH-1:0] r_data, w_data_d;
  logic [WIDTH-1:0] r_captured;
  logic [CH_W-1:0]  w_tgt_ch;
  logic [WIDTH-1:0] w_merged;
  logic             w_mismatch;

  assign w_tgt_ch = CH_W'(ch_remap({{(32-CH_W){1'b0}}, ijtag_ch_sel}, NUM_CH));

  // Only a pending IJTAG target cares about the channel.
  assign w_mismatch = (r_pend_ijtag != ijtag_select) ||
                      (ijtag_select && (r_pend_ch != w_tgt_ch));

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_pend_ijtag_d = r_pend_ijtag;
    w_pend_ch_d    = r_pend_ch;
    w_active_ch_d  = r_active_ch;
    unique case (r_state)
      SRC_FUNC: begin
        if (ijtag_select) begin
          if (SAFE_CYCLES > 0) begin
            w_state_d      = SRC_SAFE;
            w_cnt_d        = CntLoad;
            w_pend_ijtag_d = 1'b1;
            w_pend_ch_d    = w_tgt_ch;
          end else begin
            w_state_d     = SRC_IJTAG;
            w_active_ch_d = w_tgt_ch;
          end
        end
      end
      SRC_SAFE: begin
        if (w_mismatch) begin
          w_cnt_d        = CntLoad;
          w_pend_ijtag_d = ijtag_select;
          w_pend_ch_d    = w_tgt_ch;
        end else if (r_cnt == '0) begin
          if (r_pend_ijtag) begin
            w_state_d     = SRC_IJTAG;
            w_active_ch_d = r_pend_ch;
          end else begin
            w_state_d = SRC_FUNC;
          end
        end else begin
          w_cnt_d = r_cnt - CNT_W'(1);
        end
      end
      SRC_IJTAG: begin
        if (!ijtag_select || (w_tgt_ch != r_active_ch)) begin
          if (SAFE_CYCLES > 0) begin
            w_state_d      = SRC_SAFE;
            w_cnt_d        = CntLoad;
            w_pend_ijtag_d = ijtag_select;
            w_pend_ch_d    = w_tgt_ch;
          end else if (ijtag_select) begin
            w_active_ch_d = w_tgt_ch;
          end else begin
            w_state_d = SRC_FUNC;
          end
        end
      end
      default: w_state_d = SRC_FUNC;
    endcase
  end

  firebird7_in_gate1_tessent_data_mux_chsel #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_chsel (
    .i_data (ijtag_data_in),
    .i_ch   (w_active_ch_d),
    .i_func (functional_data_in),
    .i_mask (ijtag_bit_mask),
    .o_data (w_merged)
  );

  // Output word follows the state being entered, so a switch shows up one cycle after sampling.
  always_comb begin
    w_data_d = functional_data_in;
    case (w_state_d)
      SRC_SAFE:  w_data_d = SAFE_VALUE;
      SRC_IJTAG: w_data_d = w_merged;
      default:   w_data_d = functional_data_in;
    endcase
  end

  always_ff @(posedge ijtag_tck or posedge ijtag_reset) begin
    if (ijtag_reset) begin
      r_state      <= SRC_FUNC;
      r_cnt        <= '0;
      r_pend_ijtag <= 1'b0;
      r_pend_ch    <= '0;
      r_active_ch  <= '0;
      r_data       <= SAFE_VALUE;
      r_captured   <= '0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_pend_ijtag <= w_pend_ijtag_d;
      r_pend_ch    <= w_pend_ch_d;
      r_active_ch  <= w_active_ch_d;
      r_data       <= w_data_d;
      if (capture_en) r_captured <= functional_data_in;
    end
  end

  assign data_out      = r_data;
  assign captured_data = r_captured;
  assign switch_busy   = (r_state == SRC_SAFE);
  assign active_src    = r_state;
  assign active_ch     = r_active_ch;

endmodule
